burst_ram_arbiter: RTL and testbench
====================================

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_DEPTH_BITWIDTH, default 4, meaning the BurstRAM burst address width.
REQ-002 SHALL have parameter RAM_BURST_DATA_BITWIDTH, default 64, meaning the width of one burst beat.
REQ-003 SHALL have parameter RAM_BURST_DATA_COUNT, default 4, meaning the number of beats per burst.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have, per requester n in {0 = instruction, 1 = data}, these ports: reqn input 1; cmdn input 1 (0 = read, 1 = write); addrn input RAM_DEPTH_BITWIDTH; wr_datan input RAM_BURST_DATA_BITWIDTH; maskn input RAM_BURST_DATA_BITWIDTH/8; gntn output 1; rd_validn output 1; donen output 1.
REQ-007 SHALL have BurstRAM-side ports: br_cmd out 1; br_cmd_en out 1; br_addr out RAM_DEPTH_BITWIDTH; br_wr_data out RAM_BURST_DATA_BITWIDTH; br_data_mask out RAM_BURST_DATA_BITWIDTH/8; br_rd_data_valid in 1; br_busy in 1.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE, one-hot encoded.
REQ-009 IDLE: when br_busy = 0 and any reqn = 1, SHALL latch the winner into a grant register and go to ISSUE; while br_busy = 1, no grant.
REQ-010 Arbitration SHALL be round-robin: a single request wins; on simultaneous requests, the port not served last wins; the last-served register updates at each grant.
REQ-011 ISSUE: SHALL assert br_cmd_en for exactly one cycle, with br_cmd/br_addr taken from the granted port, then go to WAIT_BUSY.
REQ-012 WAIT_BUSY: SHALL go to WAIT_DONE on the first cycle br_busy = 1.
REQ-013 WAIT_DONE: SHALL count br_rd_data_valid beats with a counter of width clog2(RAM_BURST_DATA_COUNT)+1, cleared in ISSUE.
REQ-014 WAIT_DONE: SHALL exit to IDLE when br_busy = 0 and either (read and count = RAM_BURST_DATA_COUNT) or write.
REQ-015 donen SHALL pulse for one cycle on the WAIT_DONE -> IDLE transition for the granted port only.
REQ-016 gntn SHALL be high from ISSUE through WAIT_DONE for the granted port and low otherwise; gnt0 and gnt1 are never both high.
REQ-017 rd_validn SHALL equal br_rd_data_valid AND gntn (combinational); beats outside a grant are dropped.
REQ-018 br_wr_data/br_data_mask SHALL be muxed combinationally from the granted port while granted, and be 0 otherwise.
REQ-019 br_cmd_en SHALL be 0 in every state except ISSUE; br_cmd/br_addr SHALL be 0 when no port is granted.
REQ-020 Deassertion of reqn during a grant SHALL be ignored; the burst completes and donen still pulses.
REQ-021 A requester holding reqn high after donen SHALL be re-arbitrated in IDLE; a competing request wins per REQ-010.
REQ-022 Minimum turnaround SHALL be one IDLE cycle between donen and the next br_cmd_en.

Reset
REQ-023 On rst = 1, asynchronously: state = IDLE; grant = none; last-served = 1 (port 0 wins the first tie); beat counter = 0; all gntn/donen/br_cmd_en = 0.
REQ-024 rst asserted mid-burst SHALL abort immediately, with no donen; BurstRAM recovery is handled by the shared rst.

Structure
REQ-025 State encodings and the requester index constants (PORT_INSTR = 0, PORT_DATA = 1) SHALL live in a shared package, also used by the cache top.
REQ-026 Round-robin selection SHALL be a sub-module rr_select2 (inputs req[1:0] and last; output winner), combinational.

Verification
REQ-027 Only req0 (read, addr 3): br_cmd_en high one cycle at ISSUE with br_addr = 3 -> 4 rd_valid0 beats, rd_valid1 = 0 -> done0 pulse after br_busy falls.
REQ-028 req0 and req1 both high from reset: port 0 served first, then port 1 (write, mask 0xFF, data 0x0123456789ABCDEF) with br_wr_data equal to that value while granted.
REQ-029 Both requests held continuously over 6 bursts: grants alternate 0,1,0,1,0,1; gnt0 & gnt1 never both high.
REQ-030 req1 dropped in WAIT_DONE: burst completes, done1 pulses, and no re-grant to port 1.
REQ-031 br_busy held high in IDLE with req0: no br_cmd_en until br_busy = 0.
REQ-032 rst asserted during WAIT_DONE after 2 beats: outputs are 0 in the same cycle (asynchronous), no donen, and the next tie is granted to port 0.

Source files
------------

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the BurstRAM arbiter and the cache top that hosts it:
// one-hot FSM state encodings, requester indices and command codes.
package burst_ram_arbiter_pkg;

   // One-hot states. Each state owns a single bit so decode is a single flop.
   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_ISSUE     = 4'b0010,
      ST_WAIT_BUSY = 4'b0100,
      ST_WAIT_DONE = 4'b1000
   } arb_state_t;

   // Requester indices. These are also the values held in the grant and
   // last-served registers.
   localparam logic PORT_INSTR = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   // BurstRAM command codes.
   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // The requester that competes against port p.
   function automatic logic other_port(input logic p);
      return ~p;
   endfunction

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// Bundle of the two requester ports and the BurstRAM command port.
// Handshake: a requester raises reqN with cmdN/addrN/wr_dataN/maskN stable and
// holds them until doneN; gntN marks ownership of the BurstRAM from the command
// cycle until the done cycle; rd_validN qualifies one read beat per cycle;
// doneN is a single-cycle completion pulse. br_cmd_en is a single-cycle command
// strobe; the BurstRAM answers with br_busy for the whole burst.
interface burst_ram_arbiter_if #(
   parameter int RAM_DEPTH_BITWIDTH      = 4,
   parameter int RAM_BURST_DATA_BITWIDTH = 64
);

   // Requester 0 (instruction)
   logic                                   req0;
   logic                                   cmd0;
   logic [RAM_DEPTH_BITWIDTH-1:0]          addr0;
   logic [RAM_BURST_DATA_BITWIDTH-1:0]     wr_data0;
   logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   mask0;
   logic                                   gnt0;
   logic                                   rd_valid0;
   logic                                   done0;

   // Requester 1 (data)
   logic                                   req1;
   logic                                   cmd1;
   logic [RAM_DEPTH_BITWIDTH-1:0]          addr1;
   logic [RAM_BURST_DATA_BITWIDTH-1:0]     wr_data1;
   logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   mask1;
   logic                                   gnt1;
   logic                                   rd_valid1;
   logic                                   done1;

   // BurstRAM side
   logic                                   br_cmd;
   logic                                   br_cmd_en;
   logic [RAM_DEPTH_BITWIDTH-1:0]          br_addr;
   logic [RAM_BURST_DATA_BITWIDTH-1:0]     br_wr_data;
   logic [RAM_BURST_DATA_BITWIDTH/8-1:0]   br_data_mask;
   logic                                   br_rd_data_valid;
   logic                                   br_busy;

   // Arbiter view
   modport slave (
      input  req0, cmd0, addr0, wr_data0, mask0,
      input  req1, cmd1, addr1, wr_data1, mask1,
      input  br_rd_data_valid, br_busy,
      output gnt0, rd_valid0, done0,
      output gnt1, rd_valid1, done1,
      output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );

   // Requester / BurstRAM view
   modport master (
      output req0, cmd0, addr0, wr_data0, mask0,
      output req1, cmd1, addr1, wr_data1, mask1,
      output br_rd_data_valid, br_busy,
      input  gnt0, rd_valid0, done0,
      input  gnt1, rd_valid1, done1,
      input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );

endinterface

// File: rtl/burst_ram_arbiter_rr_select2.sv
// Two-way round-robin pick: a lone request wins outright; on a tie the port
// that was not served last wins.
module rr_select2
   import burst_ram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner
);

   // Winner is only meaningful when at least one request is present.
   always_comb begin
      winner = PORT_INSTR;
      if (req == 2'b11) begin
         winner = other_port(last);
      end else if (req[PORT_DATA]) begin
         winner = PORT_DATA;
      end
   end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Arbitrates the instruction and data requesters onto one BurstRAM.
// A grant covers a whole burst: one command strobe, then the BurstRAM busy
// window, then (for reads) a fixed number of data beats. All requester-facing
// outputs are decoded from registered state so an asynchronous reset clears
// them in the same cycle.
module burst_ram_arbiter
   import burst_ram_arbiter_pkg::*;
#(
   parameter int RAM_DEPTH_BITWIDTH      = 4,
   parameter int RAM_BURST_DATA_BITWIDTH = 64,
   parameter int RAM_BURST_DATA_COUNT    = 4
) (
   input  logic             clk,
   input  logic             rst,
   burst_ram_arbiter_if.slave bus,
   output arb_state_t       dbg_state
);

   localparam int CNT_W = $clog2(RAM_BURST_DATA_COUNT) + 1;
   localparam logic [CNT_W-1:0] BEATS = CNT_W'(RAM_BURST_DATA_COUNT);
   localparam int MASK_W = RAM_BURST_DATA_BITWIDTH / 8;

   arb_state_t                    state_q, state_d;
   logic                          gnt_valid_q, gnt_valid_d;
   logic                          gnt_port_q, gnt_port_d;
   logic                          last_q, last_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          cmd_q, cmd_d;
   logic [RAM_DEPTH_BITWIDTH-1:0] addr_q, addr_d;

   logic                               winner;
   logic                               cmd_en;
   logic                               done_pulse;
   logic                               gnt0_w, gnt1_w;
   logic [RAM_BURST_DATA_BITWIDTH-1:0] wr_data_sel;
   logic [MASK_W-1:0]                  mask_sel;

   rr_select2 u_rr_select2 (
      .req    ({bus.req1, bus.req0}),
      .last   (last_q),
      .winner (winner)
   );

   // Next-state, grant bookkeeping and beat counting.
   always_comb begin
      state_d     = state_q;
      gnt_valid_d = gnt_valid_q;
      gnt_port_d  = gnt_port_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      cmd_en      = 1'b0;
      done_pulse  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Never start a burst while the BurstRAM is still busy.
            if (!bus.br_busy && (bus.req0 || bus.req1)) begin
               state_d     = ST_ISSUE;
               gnt_valid_d = 1'b1;
               gnt_port_d  = winner;
               last_d      = winner;
               // Command and address are captured so a requester dropping
               // its request mid-burst cannot disturb the transfer.
               cmd_d       = (winner == PORT_DATA) ? bus.cmd1 : bus.cmd0;
               addr_d      = (winner == PORT_DATA) ? bus.addr1 : bus.addr0;
            end
         end
         ST_ISSUE: begin
            cmd_en  = 1'b1;
            cnt_d   = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (bus.br_busy) begin
               state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            if (bus.br_rd_data_valid && (cnt_q != BEATS)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (!bus.br_busy && ((cmd_q == CMD_WRITE) || (cnt_q == BEATS))) begin
               state_d     = ST_IDLE;
               gnt_valid_d = 1'b0;
               done_pulse  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   // State and grant registers; reset leaves port 0 as winner of the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_valid_q <= 1'b0;
         gnt_port_q  <= PORT_INSTR;
         last_q      <= PORT_DATA;
         cnt_q       <= '0;
         cmd_q       <= CMD_READ;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_port_q  <= gnt_port_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
      end
   end

   // Write payload follows the granted port; zero when nobody owns the RAM.
   always_comb begin
      wr_data_sel = '0;
      mask_sel    = '0;
      if (gnt0_w) begin
         wr_data_sel = bus.wr_data0;
         mask_sel    = bus.mask0;
      end else if (gnt1_w) begin
         wr_data_sel = bus.wr_data1;
         mask_sel    = bus.mask1;
      end
   end

   assign gnt0_w = gnt_valid_q && (gnt_port_q == PORT_INSTR);
   assign gnt1_w = gnt_valid_q && (gnt_port_q == PORT_DATA);

   assign bus.gnt0      = gnt0_w;
   assign bus.gnt1      = gnt1_w;
   assign bus.rd_valid0 = bus.br_rd_data_valid && gnt0_w;
   assign bus.rd_valid1 = bus.br_rd_data_valid && gnt1_w;
   assign bus.done0     = done_pulse && gnt0_w;
   assign bus.done1     = done_pulse && gnt1_w;

   assign bus.br_cmd_en    = cmd_en;
   assign bus.br_cmd       = gnt_valid_q ? cmd_q : CMD_READ;
   assign bus.br_addr      = gnt_valid_q ? addr_q : '0;
   assign bus.br_wr_data   = wr_data_sel;
   assign bus.br_data_mask = mask_sel;

   assign dbg_state = state_q;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: a small BurstRAM responder task plus
// one task per scenario with inline comparisons.
module tb_burst_ram_arbiter;
   import burst_ram_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   arb_state_t dbg_state;
   int         checks = 0;
   int         errors = 0;
   int         both_gnt = 0;

   always #5 clk = ~clk;

   burst_ram_arbiter_if #(.RAM_DEPTH_BITWIDTH(4), .RAM_BURST_DATA_BITWIDTH(64)) bus ();

   burst_ram_arbiter #(
      .RAM_DEPTH_BITWIDTH(4), .RAM_BURST_DATA_BITWIDTH(64), .RAM_BURST_DATA_COUNT(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
   );

   // Mutual exclusion monitor.
   always @(negedge clk) begin
      if (bus.gnt0 && bus.gnt1) both_gnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.req0 = 0; bus.cmd0 = 0; bus.addr0 = '0; bus.wr_data0 = '0; bus.mask0 = '0;
      bus.req1 = 0; bus.cmd1 = 0; bus.addr1 = '0; bus.wr_data1 = '0; bus.mask1 = '0;
      bus.br_rd_data_valid = 0; bus.br_busy = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      drive_idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Plays the BurstRAM for one burst and reports what it observed.
   task automatic do_burst(input int drop1_beat, output int gport, output logic cmd,
                           output logic [3:0] addr, output logic [63:0] wdata,
                           output logic [7:0] mask, output int wait_cyc, output int extra_en,
                           output int beats0, output int beats1, output int done0_n,
                           output int done1_n, output bit timeout);
      bit found;
      int nb;
      gport = -1; cmd = 0; addr = 0; wdata = 0; mask = 0; wait_cyc = 0; extra_en = 0;
      beats0 = 0; beats1 = 0; done0_n = 0; done1_n = 0; timeout = 0; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         wait_cyc++;
         if (bus.br_cmd_en) begin
            found = 1;
            gport = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
            cmd   = bus.br_cmd;
            addr  = bus.br_addr;
            wdata = bus.br_wr_data;
            mask  = bus.br_data_mask;
         end
      end
      if (!found) begin
         timeout = 1;
         return;
      end
      bus.br_busy = 1;
      @(negedge clk);
      if (bus.br_cmd_en) extra_en++;
      nb = (cmd == CMD_READ) ? 4 : 0;
      for (int b = 0; b < nb; b++) begin
         @(negedge clk);
         if (b == drop1_beat) bus.req1 = 0;
         bus.br_rd_data_valid = 1;
         #1;
         if (bus.rd_valid0) beats0++;
         if (bus.rd_valid1) beats1++;
         if (bus.br_cmd_en) extra_en++;
      end
      @(negedge clk);
      bus.br_rd_data_valid = 0;
      bus.br_busy = 0;
      #1;
      if (bus.done0) done0_n++;
      if (bus.done1) done1_n++;
      if (bus.br_cmd_en) extra_en++;
      @(negedge clk);
      #1;
      if (bus.done0) done0_n++;
      if (bus.done1) done1_n++;
      if (bus.br_cmd_en) extra_en++;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      bus.req0 = 1; bus.req1 = 1; bus.cmd0 = 1; bus.addr0 = 4'h5;
      bus.wr_data0 = 64'hFFFF_FFFF_FFFF_FFFF; bus.mask0 = 8'hFF; bus.br_rd_data_valid = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++; $display("FAIL reset_state got %b want %b", dbg_state, ST_IDLE);
      end
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.br_cmd_en, bus.br_cmd,
           bus.rd_valid0, bus.rd_valid1} !== 8'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b%b%b%b%b%b%b%b want 00000000", bus.gnt0, bus.gnt1,
                  bus.done0, bus.done1, bus.br_cmd_en, bus.br_cmd, bus.rd_valid0, bus.rd_valid1);
      end
      checks++;
      if ({bus.br_addr, bus.br_data_mask} !== 12'h0 || bus.br_wr_data !== 64'h0) begin
         errors++;
         $display("FAIL reset_bus got addr %h mask %h data %h want 0", bus.br_addr,
                  bus.br_data_mask, bus.br_wr_data);
      end
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      int gp, wc, ee, b0, b1, d0, d1;
      logic c; logic [3:0] a; logic [63:0] wd; logic [7:0] m; bit to;
      int en_after;
      apply_reset();
      bus.req0 = 1; bus.cmd0 = CMD_READ; bus.addr0 = 4'd3;
      do_burst(-1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
      bus.req0 = 0;
      checks++;
      if (to !== 1'b0) begin errors++; $display("FAIL single_timeout got %0b want 0", to); end
      checks++;
      if (gp !== 0) begin errors++; $display("FAIL single_port got %0d want 0", gp); end
      checks++;
      if (a !== 4'd3 || c !== CMD_READ) begin
         errors++; $display("FAIL single_cmd got addr %0d cmd %0b want 3 0", a, c);
      end
      checks++;
      if (ee !== 0) begin errors++; $display("FAIL single_cmd_en_len got extra %0d want 0", ee); end
      checks++;
      if (b0 !== 4 || b1 !== 0) begin
         errors++; $display("FAIL single_beats got %0d/%0d want 4/0", b0, b1);
      end
      checks++;
      if (d0 !== 1 || d1 !== 0) begin
         errors++; $display("FAIL single_done got %0d/%0d want 1/0", d0, d1);
      end
      en_after = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.br_cmd_en || bus.gnt0) en_after++;
      end
      checks++;
      if (en_after !== 0) begin errors++; $display("FAIL single_quiet got %0d want 0", en_after); end
   endtask

   task automatic test_tie();
      int gp, wc, ee, b0, b1, d0, d1;
      logic c; logic [3:0] a; logic [63:0] wd; logic [7:0] m; bit to;
      apply_reset();
      bus.req0 = 1; bus.cmd0 = CMD_READ; bus.addr0 = 4'd3;
      bus.req1 = 1; bus.cmd1 = CMD_WRITE; bus.addr1 = 4'hA;
      bus.wr_data1 = 64'h0123_4567_89AB_CDEF; bus.mask1 = 8'hFF;
      do_burst(-1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
      checks++;
      if (to !== 1'b0 || gp !== 0 || d0 !== 1) begin
         errors++; $display("FAIL tie_first got port %0d done0 %0d to %0b want 0 1 0", gp, d0, to);
      end
      do_burst(-1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
      bus.req0 = 0; bus.req1 = 0;
      checks++;
      if (to !== 1'b0 || gp !== 1) begin
         errors++; $display("FAIL tie_second got port %0d to %0b want 1 0", gp, to);
      end
      checks++;
      if (c !== CMD_WRITE || a !== 4'hA || wd !== 64'h0123_4567_89AB_CDEF || m !== 8'hFF) begin
         errors++;
         $display("FAIL tie_write got cmd %0b addr %h data %h mask %h want 1 a 0123456789abcdef ff",
                  c, a, wd, m);
      end
      checks++;
      if (d1 !== 1 || d0 !== 0 || b0 !== 0 || b1 !== 0) begin
         errors++; $display("FAIL tie_write_done got d0 %0d d1 %0d b0 %0d b1 %0d want 0 1 0 0",
                            d0, d1, b0, b1);
      end
      checks++;
      if (wc !== 1) begin errors++; $display("FAIL tie_turnaround got %0d want 1", wc); end
   endtask

   task automatic test_back_to_back();
      int gp, wc, ee, b0, b1, d0, d1, base;
      logic c; logic [3:0] a; logic [63:0] wd; logic [7:0] m; bit to;
      apply_reset();
      base = both_gnt;
      bus.req0 = 1; bus.cmd0 = CMD_READ; bus.addr0 = 4'd1;
      bus.req1 = 1; bus.cmd1 = CMD_WRITE; bus.addr1 = 4'd2; bus.wr_data1 = 64'h55; bus.mask1 = 8'h0F;
      for (int k = 0; k < 6; k++) begin
         do_burst(-1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
         checks++;
         if (to !== 1'b0 || gp !== (k % 2)) begin
            errors++; $display("FAIL b2b_port%0d got %0d want %0d", k, gp, k % 2);
         end
         checks++;
         if (wc !== 1 || (d0 + d1) !== 1) begin
            errors++; $display("FAIL b2b_timing%0d got wait %0d done %0d want 1 1", k, wc, d0 + d1);
         end
      end
      bus.req0 = 0; bus.req1 = 0;
      @(negedge clk);
      checks++;
      if (both_gnt - base !== 0) begin
         errors++; $display("FAIL b2b_exclusive got %0d want 0", both_gnt - base);
      end
   endtask

   task automatic test_drop_req();
      int gp, wc, ee, b0, b1, d0, d1, seen;
      logic c; logic [3:0] a; logic [63:0] wd; logic [7:0] m; bit to;
      apply_reset();
      bus.req1 = 1; bus.cmd1 = CMD_READ; bus.addr1 = 4'd6;
      do_burst(1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
      checks++;
      if (to !== 1'b0 || gp !== 1 || a !== 4'd6) begin
         errors++; $display("FAIL drop_grant got port %0d addr %0d want 1 6", gp, a);
      end
      checks++;
      if (b1 !== 4 || b0 !== 0 || d1 !== 1) begin
         errors++; $display("FAIL drop_complete got b1 %0d b0 %0d d1 %0d want 4 0 1", b1, b0, d1);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.br_cmd_en || bus.gnt1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL drop_regrant got %0d want 0", seen); end
   endtask

   task automatic test_busy_idle();
      int gp, wc, ee, b0, b1, d0, d1, seen;
      logic c; logic [3:0] a; logic [63:0] wd; logic [7:0] m; bit to;
      apply_reset();
      bus.br_busy = 1;
      bus.req0 = 1; bus.cmd0 = CMD_READ; bus.addr0 = 4'd2;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.br_cmd_en || bus.gnt0 || dbg_state !== ST_IDLE) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL busy_hold got %0d want 0", seen); end
      bus.br_busy = 0;
      do_burst(-1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
      bus.req0 = 0;
      checks++;
      if (to !== 1'b0 || gp !== 0 || a !== 4'd2 || wc !== 1) begin
         errors++; $display("FAIL busy_release got port %0d addr %0d wait %0d want 0 2 1", gp, a, wc);
      end
   endtask

   task automatic test_reset_mid();
      int gp, wc, ee, b0, b1, d0, d1, dn;
      logic c; logic [3:0] a; logic [63:0] wd; logic [7:0] m; bit to, found;
      apply_reset();
      bus.req0 = 1; bus.cmd0 = CMD_READ; bus.addr0 = 4'd3;
      bus.req1 = 1; bus.cmd1 = CMD_READ; bus.addr1 = 4'd5;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (bus.br_cmd_en) found = 1;
      end
      checks++;
      if (found !== 1'b1 || bus.gnt0 !== 1'b1) begin
         errors++; $display("FAIL rmid_first got found %0b gnt0 %0b want 1 1", found, bus.gnt0);
      end
      bus.br_busy = 1;
      @(negedge clk);
      dn = 0;
      repeat (2) begin
         @(negedge clk);
         bus.br_rd_data_valid = 1;
         #1;
         if (bus.done0 || bus.done1) dn++;
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.rd_valid0, bus.done0, bus.br_cmd_en} !== 5'b0 ||
          dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL rmid_async got gnt0 %0b gnt1 %0b rv0 %0b done0 %0b en %0b state %b want 0",
                  bus.gnt0, bus.gnt1, bus.rd_valid0, bus.done0, bus.br_cmd_en, dbg_state);
      end
      @(negedge clk);
      if (bus.done0 || bus.done1) dn++;
      bus.br_rd_data_valid = 0; bus.br_busy = 0;
      rst = 1'b0;
      checks++;
      if (dn !== 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", dn); end
      do_burst(-1, gp, c, a, wd, m, wc, ee, b0, b1, d0, d1, to);
      bus.req0 = 0; bus.req1 = 0;
      checks++;
      if (to !== 1'b0 || gp !== 0 || a !== 4'd3) begin
         errors++; $display("FAIL rmid_tie got port %0d addr %0d want 0 3", gp, a);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_back_to_back();
      test_drop_req();
      test_busy_idle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
